// File: rtl/delay_line_pkg.sv
// Shared definitions for the multi-channel pulse delay line.
//   - ch_state_t      : per-channel FSM state (normal run / overflow drain)
//   - DEF_MIN_DELAY   : default smallest honoured delay, in cycles
//   - PIPE_OFFSET     : cycles between first-synchroniser capture and FIFO push
//   - target_reached  : wrap-safe "now has reached or passed target" compare
package delay_line_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } ch_state_t;

  localparam int DEF_MIN_DELAY = 4;

  // Capture in sync1, then sync2, then the edge is pushed one cycle later
  // using the 'now' of that cycle: the push sees 'now' two counts ahead of
  // the capture cycle.
  localparam int PIPE_OFFSET = 2;

  // Operands are zero-extended to 32 bits; modular subtraction keeps the low
  // cnt_w bits exact, so the sign of the cnt_w-bit difference is its MSB.
  function automatic logic target_reached(input logic [31:0] now_v,
                                          input logic [31:0] tgt_v,
                                          input int unsigned cnt_w);
    logic [31:0] diff;
    logic [4:0]  msb;
    diff = now_v - tgt_v;
    msb  = 5'(cnt_w - 1);
    return ~diff[msb];
  endfunction

endpackage

// File: rtl/delay_line_channel.sv
// One channel of the delay line: 2-flop synchroniser, edge detect,
// timestamp FIFO, RUN/DRAIN overflow FSM and toggling output.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_in             asynchronous pulse input
//   i_delay          requested delay in cycles (sampled when an edge is pushed)
//   i_now            shared free-running timestamp
//   i_ovf_clr        synchronous clear of the sticky overflow flag
//   o_out            delayed pulse output
//   o_ovf            sticky overflow flag
//   o_nonempty       FIFO holds at least one pending edge
module delay_line_channel
  import delay_line_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DEPTH     = 8,
  parameter int MIN_DELAY = DEF_MIN_DELAY
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in,
  input  logic [CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0] i_now,
  input  logic             i_ovf_clr,
  output logic             o_out,
  output logic             o_ovf,
  output logic             o_nonempty
);

  localparam int AW = $clog2(DEPTH);

  logic             r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  ch_state_t        r_state;
  logic             r_out, r_ovf;

  logic             w_edge, w_full, w_empty, w_pop;
  logic             w_try_push, w_push, w_overflow;
  logic [CNT_W-1:0] w_eff_delay, w_target;

  assign w_edge  = r_sync2 ^ r_prev;
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  assign w_eff_delay = (i_delay < CNT_W'(MIN_DELAY)) ? CNT_W'(MIN_DELAY) : i_delay;
  assign w_target    = i_now + w_eff_delay - CNT_W'(PIPE_OFFSET);

  // Head fires once its target is reached or already passed, so an entry
  // made stale by a delay decrease goes out immediately instead of waiting
  // for the counter to wrap.
  assign w_pop = !w_empty &&
                 target_reached(32'(i_now), 32'(r_mem[r_rd_ptr]), CNT_W);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign w_try_push = w_edge && (r_state == ST_RUN);
  assign w_push     = w_try_push && (!w_full || w_pop);
  assign w_overflow = w_try_push && w_full && !w_pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_prev   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= ST_RUN;
      r_out    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
      // Tracking the synchronised level every cycle also realigns the
      // edge detector when DRAIN hands back to RUN.
      r_prev  <= r_sync2;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        ST_RUN:   if (w_overflow) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_empty)    r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase

      // Only timestamps are stored; edges alternate so each pop toggles.
      // Leaving DRAIN re-syncs the output to the live input level, undoing
      // any polarity error left by the dropped edges.
      if (w_pop)
        r_out <= ~r_out;
      else if ((r_state == ST_DRAIN) && w_empty)
        r_out <= r_sync2;

      if (w_overflow)     r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Storage needs no reset: entries are only read behind the count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_target;
  end

  assign o_out      = r_out;
  assign o_ovf      = r_ovf;
  assign o_nonempty = !w_empty;

endmodule

// File: rtl/delay_line_multi.sv
// Multi-channel runtime-programmable pulse delay line. Each channel replays
// the edges of its input exactly eff_delay cycles after they are sampled.
// Ports:
//   clk_in        system clock
//   rst_n_in      asynchronous active-low reset
//   in            per-channel asynchronous pulse inputs
//   delay_cycles  per-channel delay, channel k at [k*CNT_W +: CNT_W]
//   ovf_clr       synchronous clear of all sticky overflow flags
//   out           delayed pulse outputs
//   ovf           sticky per-channel overflow flags
//   led0          registered OR of ovf
//   led1          registered OR of per-channel FIFO non-empty
module delay_line_multi
  import delay_line_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 16,
  parameter int DEPTH     = 8,
  parameter int MIN_DELAY = DEF_MIN_DELAY
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [CHANNELS-1:0]       in,
  input  logic [CHANNELS*CNT_W-1:0] delay_cycles,
  input  logic                      ovf_clr,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       ovf,
  output logic                      led0,
  output logic                      led1
);

  logic [CNT_W-1:0]    r_now;
  logic [CHANNELS-1:0] w_nonempty;
  logic                r_led0, r_led1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_now  <= '0;
      r_led0 <= 1'b0;
      r_led1 <= 1'b0;
    end else begin
      r_now  <= r_now + 1'b1;
      r_led0 <= |ovf;
      r_led1 <= |w_nonempty;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    delay_line_channel #(
      .CNT_W     (CNT_W),
      .DEPTH     (DEPTH),
      .MIN_DELAY (MIN_DELAY)
    ) u_ch (
      .i_clk      (clk_in),
      .i_rst_n    (rst_n_in),
      .i_in       (in[k]),
      .i_delay    (delay_cycles[k*CNT_W +: CNT_W]),
      .i_now      (r_now),
      .i_ovf_clr  (ovf_clr),
      .o_out      (out[k]),
      .o_ovf      (ovf[k]),
      .o_nonempty (w_nonempty[k])
    );
  end

  assign led0 = r_led0;
  assign led1 = r_led1;

endmodule

// File: tb/tb_delay_line_multi.sv
// Self-checking bench for delay_line_multi: latency table, behavioural
// model runs (periodic and random), counter wrap, overflow/drain,
// delay decrease and mid-burst reset.
module tb_delay_line_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  din;
  logic [63:0] dly;
  logic        ovf_clr;
  logic [3:0]  dout, dovf;
  logic        led0, led1;

  logic        w_rst_n;
  logic [0:0]  w_in;
  logic [7:0]  w_dly;
  logic        w_clr;
  logic [0:0]  w_out, w_ovf;
  logic        w_led0, w_led1;

  int checks = 0;
  int errors = 0;
  logic [3:0] hist [0:16383];

  always #5 clk = ~clk;

  delay_line_multi #(.CHANNELS(4), .CNT_W(16), .DEPTH(4), .MIN_DELAY(4)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .in(din), .delay_cycles(dly),
    .ovf_clr(ovf_clr), .out(dout), .ovf(dovf), .led0(led0), .led1(led1));

  delay_line_multi #(.CHANNELS(1), .CNT_W(8), .DEPTH(8), .MIN_DELAY(4)) wdut (
    .clk_in(clk), .rst_n_in(w_rst_n), .in(w_in), .delay_cycles(w_dly),
    .ovf_clr(w_clr), .out(w_out), .ovf(w_ovf), .led0(w_led0), .led1(w_led1));

  typedef struct {
    int ch;
    int dl;
    int width;
    int exp_lat;
    int exp_w;
  } lat_vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dly(input int k, input int d);
    dly[k*16 +: 16] = 16'(d);
  endtask

  function automatic int eff_of(input int k);
    int d;
    d = int'(dly[k*16 +: 16]);
    return (d < 4) ? 4 : d;
  endfunction

  // Leaves the bench at a falling edge with reset released; the next
  // rising edge is cycle 0 of the test.
  task automatic reset_main();
    @(negedge clk);
    rst_n = 1'b0;
    din = '0;
    ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: with no overflow, out[k] after edge c equals the input
  // sampled at edge c - eff_delay (zero before the first sample).
  task automatic run_model(input int ncyc, input bit rnd);
    int eff [4];
    int seg [4];
    logic [3:0] lvl, exp;
    for (int k = 0; k < 4; k++) begin
      eff[k] = eff_of(k);
      seg[k] = int'($urandom_range(1, eff[k]));
    end
    reset_main();
    lvl = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (rnd) begin
        for (int k = 0; k < 4; k++) begin
          if (seg[k] == 0) begin
            lvl[k] = ~lvl[k];
            seg[k] = int'($urandom_range(eff[k] / 3 + 1, eff[k] + 20));
          end
          seg[k]--;
        end
      end else begin
        lvl = {3'b000, ((c % 1350) < 135)};
      end
      din = lvl;
      hist[c] = lvl;
      tick();
      for (int k = 0; k < 4; k++)
        exp[k] = (c >= eff[k]) ? hist[c - eff[k]][k] : 1'b0;
      chk(rnd ? "rand_out" : "periodic_out", 64'(dout), 64'(exp));
      chk(rnd ? "rand_ovf" : "periodic_ovf", 64'(dovf), 64'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lat_vec_t tbl [6];
    int rose, fell, mism;
    logic lv;

    tbl[0] = '{0,   2, 5,   4, 5};
    tbl[1] = '{0,   0, 3,   4, 3};
    tbl[2] = '{1,   4, 1,   4, 1};
    tbl[3] = '{2,  37, 10, 37, 10};
    tbl[4] = '{3,   3, 2,   4, 2};
    tbl[5] = '{1, 255, 7, 255, 7};

    rst_n = 1'b0; din = '0; dly = '0; ovf_clr = 1'b0;
    w_rst_n = 1'b0; w_in = '0; w_dly = 8'd100; w_clr = 1'b0;
    #23;
    chk("reset_out",  64'(dout), 64'd0);
    chk("reset_ovf",  64'(dovf), 64'd0);
    chk("reset_led0", 64'(led0), 64'd0);
    chk("reset_led1", 64'(led1), 64'd0);

    // Latency and pulse-width table
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) set_dly(k, 100);
      set_dly(tbl[i].ch, tbl[i].dl);
      reset_main();
      rose = -1; fell = -1;
      for (int c = 0; c < 3000; c++) begin
        din = '0;
        din[tbl[i].ch] = (c < tbl[i].width);
        tick();
        if (rose < 0 && dout[tbl[i].ch]) rose = c;
        else if (rose >= 0 && fell < 0 && !dout[tbl[i].ch]) fell = c;
        @(negedge clk);
        if (fell >= 0) break;
      end
      chk("tbl_latency", 64'(rose), 64'(tbl[i].exp_lat));
      chk("tbl_width", 64'(fell - rose), 64'(tbl[i].exp_w));
    end

    // Periodic 135-cycle pulse, D=1350, on channel 0
    set_dly(0, 1350); set_dly(1, 10); set_dly(2, 20); set_dly(3, 30);
    run_model(1350 * 11, 1'b0);

    // Random traffic, random delays on all channels
    for (int k = 0; k < 4; k++) set_dly(k, int'($urandom_range(0, 900)));
    run_model(4000, 1'b1);

    // Counter wrap on the 8-bit instance: capture at now=200, fire at 44
    @(negedge clk);
    w_rst_n = 1'b1;
    mism = 0;
    for (int c = 0; c < 320; c++) begin
      w_in = (c >= 200);
      tick();
      if (w_out[0] !== (c >= 300)) mism++;
      if (c == 300) chk("wrap_toggle", 64'(w_out), 64'd1);
      @(negedge clk);
    end
    chk("wrap_glitches", 64'(mism), 64'd0);
    chk("wrap_ovf", 64'(w_ovf), 64'd0);

    // Overflow: 11 edges every 3 cycles into a 4-deep FIFO, D=1000
    set_dly(0, 1000); set_dly(1, 50); set_dly(2, 50); set_dly(3, 50);
    reset_main();
    for (int c = 0; c < 1020; c++) begin
      lv = (c <= 30) ? 1'(((c / 3) + 1) & 1) : 1'b1;
      din = {3'b000, lv};
      ovf_clr = (c == 13 || c == 14);
      tick();
      case (c)
        10:   chk("ovf_led1_busy", 64'(led1), 64'd1);
        13:   chk("ovf_before", 64'(dovf[0]), 64'd0);
        14: begin
          chk("ovf_set_beats_clr", 64'(dovf[0]), 64'd1);
          chk("ovf_led0_lag", 64'(led0), 64'd0);
        end
        15:   chk("ovf_led0", 64'(led0), 64'd1);
        999:  chk("drain_out_999", 64'(dout[0]), 64'd0);
        1000: chk("drain_out_1000", 64'(dout[0]), 64'd1);
        1003: chk("drain_out_1003", 64'(dout[0]), 64'd0);
        1009: chk("drain_out_1009", 64'(dout[0]), 64'd0);
        1012: begin
          chk("drain_restored", 64'(dout[0]), 64'd1);
          chk("drain_led1_idle", 64'(led1), 64'd0);
          chk("drain_ovf_sticky", 64'(dovf[0]), 64'd1);
        end
        default: ;
      endcase
      @(negedge clk);
    end
    ovf_clr = 1'b1;
    tick();
    chk("ovf_clr", 64'(dovf), 64'd0);
    @(negedge clk);
    ovf_clr = 1'b0;
    tick();
    chk("ovf_clr_led0", 64'(led0), 64'd0);
    @(negedge clk);

    // Delay decrease with an edge queued: fall fires right after the rise
    set_dly(0, 500);
    reset_main();
    mism = 0;
    for (int c = 0; c < 620; c++) begin
      din = {3'b000, (c < 10)};
      if (c == 5) set_dly(0, 50);
      tick();
      if (dout[0] !== (c == 500)) mism++;
      if (c == 500) chk("dec_head_fires", 64'(dout[0]), 64'd1);
      if (c == 501) chk("dec_next_fires", 64'(dout[0]), 64'd0);
      @(negedge clk);
    end
    chk("dec_sequence", 64'(mism), 64'd0);

    // Four channels, reset asserted mid-burst, then resume with inputs high
    set_dly(0, 10); set_dly(1, 20); set_dly(2, 30); set_dly(3, 40);
    reset_main();
    for (int c = 0; c < 15; c++) begin
      din = 4'hF;
      tick();
      @(negedge clk);
    end
    chk("burst_pre_reset", 64'(dout), 64'b0001);
    rst_n = 1'b0;
    #1;
    chk("burst_async_out", 64'(dout), 64'd0);
    repeat (2) @(negedge clk);
    chk("burst_fifo_empty", 64'(led1), 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 46; c++) begin
      tick();
      chk("burst_resume", 64'(dout),
          64'({c >= 40, c >= 30, c >= 20, c >= 10}));
      @(negedge clk);
    end
    chk("burst_ovf", 64'(dovf), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
